// File: rtl/pattern_sweep_ctrl.sv
// Exhaustive input-pattern sequencer: drives every pattern into a circuit-under-test,
// waits a settle time, samples the response and hands (pattern, response) records downstream.
module pattern_sweep_ctrl #(
    parameter int IN_W   = 2,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [IN_W-1:0]  rec_pattern,
    output logic [OUT_W-1:0] rec_response,
    output logic [IN_W:0]    resp_ones,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } state_e;

    localparam logic [IN_W-1:0]  LAST_PAT   = '1;
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

    state_e             state_q, state_d;
    logic [IN_W-1:0]    dut_in_q, dut_in_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IN_W-1:0]    rec_pattern_q, rec_pattern_d;
    logic [OUT_W-1:0]   rec_response_q, rec_response_d;
    logic               rec_valid_q, rec_valid_d;
    logic [IN_W:0]      resp_ones_q, resp_ones_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    wire last_pat = (dut_in_q == LAST_PAT);

    // NOTE: state is updated only with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CK) begin
        if (reset) begin
            state_q        <= IDLE;
            dut_in_q       <= '0;
            cnt_q          <= '0;
            rec_pattern_q  <= '0;
            rec_response_q <= '0;
            rec_valid_q    <= 1'b0;
            resp_ones_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            dut_in_q       <= dut_in_d;
            cnt_q          <= cnt_d;
            rec_pattern_q  <= rec_pattern_d;
            rec_response_q <= rec_response_d;
            rec_valid_q    <= rec_valid_d;
            resp_ones_q    <= resp_ones_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // NOTE: every always_comb output gets a hold default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = WAIT;
                WAIT:    if (cnt_q == '0) state_d = EMIT;
                EMIT:    if (rec_ready) state_d = last_pat ? IDLE : WAIT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dut_in_d       = dut_in_q;
        cnt_d          = cnt_q;
        rec_pattern_d  = rec_pattern_q;
        rec_response_d = rec_response_q;
        rec_valid_d    = rec_valid_q;
        resp_ones_d    = resp_ones_q;
        busy_d         = busy_q;
        done_d         = done_q;
        if (abort) begin
            // Cancel keeps done and the partial activity count for inspection.
            dut_in_d    = '0;
            rec_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dut_in_d    = '0;
                        cnt_d       = SETTLE_CNT;
                        resp_ones_d = '0;
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        rec_pattern_d  = dut_in_q;
                        rec_response_d = dut_out;
                        rec_valid_d    = 1'b1;
                        if (dut_out != '0) resp_ones_d = resp_ones_q + (IN_W+1)'(1);
                    end
                end
                EMIT: begin
                    if (rec_ready) begin
                        rec_valid_d = 1'b0;
                        if (last_pat) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            dut_in_d = dut_in_q + IN_W'(1);
                            cnt_d    = SETTLE_CNT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_in       = dut_in_q;
    assign rec_valid    = rec_valid_q;
    assign rec_pattern  = rec_pattern_q;
    assign rec_response = rec_response_q;
    assign resp_ones    = resp_ones_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_pattern_sweep_ctrl.sv
// Bench for pattern_sweep_ctrl: instance A (SETTLE=1, AND stub), instance B (SETTLE=0, registered XOR stub).
module tb_pattern_sweep_ctrl;
    localparam int IN_W  = 2;
    localparam int OUT_W = 1;
    localparam int NPAT  = 1 << IN_W;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic reset, start, abort, rec_ready;
    int   sel;
    int   total = 0;
    int   bad   = 0;

    logic             start_a, start_b;
    logic [IN_W-1:0]  dut_in_a, dut_in_b, rec_pattern_a, rec_pattern_b;
    logic [OUT_W-1:0] dut_out_a, dut_out_b, rec_response_a, rec_response_b;
    logic             rec_valid_a, rec_valid_b, busy_a, busy_b, done_a, done_b;
    logic [IN_W:0]    resp_ones_a, resp_ones_b;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);

    assign dut_out_a = dut_in_a[1] & dut_in_a[0];
    always @(posedge CK) dut_out_b <= ^dut_in_b;

    pattern_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1), .CNT_W(8)) u_a (
        .CK(CK), .reset(reset), .start(start_a), .abort(abort),
        .dut_in(dut_in_a), .dut_out(dut_out_a),
        .rec_valid(rec_valid_a), .rec_ready(rec_ready),
        .rec_pattern(rec_pattern_a), .rec_response(rec_response_a),
        .resp_ones(resp_ones_a), .busy(busy_a), .done(done_a)
    );

    pattern_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(0), .CNT_W(8)) u_b (
        .CK(CK), .reset(reset), .start(start_b), .abort(abort),
        .dut_in(dut_in_b), .dut_out(dut_out_b),
        .rec_valid(rec_valid_b), .rec_ready(rec_ready),
        .rec_pattern(rec_pattern_b), .rec_response(rec_response_b),
        .resp_ones(resp_ones_b), .busy(busy_b), .done(done_b)
    );

    logic [IN_W-1:0]  m_dut_in, m_pattern;
    logic [OUT_W-1:0] m_resp;
    logic             m_valid, m_busy, m_done;
    logic [IN_W:0]    m_ones;

    always_comb begin
        m_dut_in  = dut_in_a;
        m_pattern = rec_pattern_a;
        m_resp    = rec_response_a;
        m_valid   = rec_valid_a;
        m_busy    = busy_a;
        m_done    = done_a;
        m_ones    = resp_ones_a;
        if (sel == 1) begin
            m_dut_in  = dut_in_b;
            m_pattern = rec_pattern_b;
            m_resp    = rec_response_b;
            m_valid   = rec_valid_b;
            m_busy    = busy_b;
            m_done    = done_b;
            m_ones    = resp_ones_b;
        end
    end

    // Reference: expected response for pattern p on the selected instance.
    function automatic logic [OUT_W-1:0] model_resp(input int s, input int p);
        logic [IN_W-1:0] prev;
        if (s == 0) return OUT_W'(p == NPAT - 1);
        // Registered stub lags one pattern; pattern 0 follows 3 or the reset value 0 (both even parity).
        prev = IN_W'(p + NPAT - 1);
        return OUT_W'(^prev);
    endfunction

    function automatic int model_settle(input int s);
        return (s == 0) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_dut_in"}, 32'(m_dut_in), 0);
        check({tag, "_pattern"}, 32'(m_pattern), 0);
        check({tag, "_resp"}, 32'(m_resp), 0);
        check({tag, "_ones"}, 32'(m_ones), 0);
        check({tag, "_valid"}, 32'(m_valid), 0);
        check({tag, "_busy"}, 32'(m_busy), 0);
        check({tag, "_done"}, 32'(m_done), 0);
    endtask

    // mode 0: ready high; 1: 5-cycle stall on pattern 1; 2: random ready; 3: start pulse mid-sweep
    task automatic sweep(input int mode, input string tag);
        int   cyc, idx, ones, stalls, rises, pulsed, exp_ones;
        logic done_prev;
        idx = 0; ones = 0; stalls = 0; rises = 0; pulsed = 0; exp_ones = 0;
        for (int p = 0; p < NPAT; p++) if (model_resp(sel, p) != '0) exp_ones++;
        rec_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        done_prev = m_done;
        check({tag, "_busy_rise"}, 32'(m_busy), 1);
        while (m_busy && cyc < 300) begin
            rec_ready = 1'b1;
            if (mode == 1 && m_valid && m_pattern == 1 && stalls < 5) rec_ready = 1'b0;
            if (mode == 2) rec_ready = 1'($urandom_range(0, 1));
            if (m_valid && !rec_ready) begin
                stalls++;
                if (mode == 1) begin
                    check({tag, "_hold_pat"}, 32'(m_pattern), 1);
                    check({tag, "_hold_resp"}, 32'(m_resp), 32'(model_resp(sel, 1)));
                    check({tag, "_hold_dut_in"}, 32'(m_dut_in), 1);
                end
            end
            if (mode == 3 && m_dut_in == 1 && pulsed == 0) begin
                start = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (m_valid && rec_ready) begin
                check({tag, "_rec_pat"}, 32'(m_pattern), 32'(idx));
                check({tag, "_rec_resp"}, 32'(m_resp), 32'(model_resp(sel, idx)));
                idx++;
            end
            step();
            cyc++;
            if (m_done && !done_prev) rises++;
            done_prev = m_done;
        end
        start = 1'b0;
        rec_ready = 1'b1;
        check({tag, "_finished"}, 32'(m_busy), 0);
        check({tag, "_cycles"}, 32'(cyc), 32'(NPAT * (model_settle(sel) + 2) + stalls));
        check({tag, "_records"}, 32'(idx), 32'(NPAT));
        check({tag, "_ones"}, 32'(m_ones), 32'(exp_ones));
        check({tag, "_done"}, 32'(m_done), 1);
        check({tag, "_done_rises"}, 32'(rises), 1);
        check({tag, "_valid_low"}, 32'(m_valid), 0);
        check({tag, "_last_pat"}, 32'(m_dut_in), 32'(NPAT - 1));
        if (mode == 1) check({tag, "_stalls"}, 32'(stalls), 5);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; abort = 1'b0; rec_ready = 1'b0; sel = 0;
        repeat (3) step();
        sel = 0; check_idle_zero("reset_a");
        sel = 1; check_idle_zero("reset_b");
        reset = 1'b0;
        step();

        sel = 0;
        sweep(0, "basic");
        sweep(1, "backpressure");
        sweep(2, "rand_a0");
        sweep(2, "rand_a1");
        sweep(3, "start_busy");

        sel = 1;
        sweep(0, "settle0");
        sweep(2, "settle0_rand");

        // Abort while idle leaves done set.
        sel = 0;
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_idle_done", 32'(m_done), 1);
        check("abort_idle_dut_in", 32'(m_dut_in), 0);

        // Abort while waiting on pattern 2.
        rec_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!(m_dut_in == 2 && !m_valid && m_busy) && n < 50) begin step(); n++; end
        check("abort_reach_wait2", 32'(n < 50), 1);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_busy", 32'(m_busy), 0);
        check("abort_valid", 32'(m_valid), 0);
        check("abort_dut_in", 32'(m_dut_in), 0);
        check("abort_done", 32'(m_done), 0);
        check("abort_ones_partial", 32'(m_ones), 0);
        sweep(0, "after_abort");

        // Reset while a record is stalled in EMIT.
        rec_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!m_valid && n < 50) begin step(); n++; end
        check("rst_emit_valid", 32'(m_valid), 1);
        step();
        check("rst_emit_held", 32'(m_valid), 1);
        reset = 1'b1; step(); reset = 1'b0;
        check_idle_zero("rst_mid_emit");
        sweep(0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
